// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word over valid/ready
// and shifts it out one bit per clock with first/last frame markers.
module piso_shift_tx #(
  parameter int WIDTH     = 5,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pi_data,
  input  logic             pi_valid,
  output logic             pi_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_first,
  output logic             so_last,
  output logic             busy
);
  localparam int            CW         = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);
  localparam logic [3:0]    GAP_LAST   = 4'(GAP - 1);
  localparam bit            NO_GAP     = (GAP == 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [3:0]       gcnt;
  logic             take;

  // Ready on the last bit only when frames may run back-to-back.
  assign pi_ready = (state == ST_IDLE) ||
                    (NO_GAP && state == ST_SHIFT && cnt == CNT_LAST);
  assign take     = pi_valid && pi_ready;
  assign busy     = (state != ST_IDLE);

  function automatic logic head(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // The first bit goes straight to so on acceptance; sreg holds the rest,
  // pre-shifted so its output end is always the next bit due.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sreg     <= '0;
      cnt      <= '0;
      gcnt     <= '0;
      so       <= 1'b0;
      so_valid <= 1'b0;
      so_first <= 1'b0;
      so_last  <= 1'b0;
    end else if (take) begin
      state    <= ST_SHIFT;
      sreg     <= adv(pi_data);
      cnt      <= '0;
      gcnt     <= '0;
      so       <= head(pi_data);
      so_valid <= 1'b1;
      so_first <= 1'b1;
      so_last  <= 1'b0;
    end else begin
      unique case (state)
        ST_SHIFT: begin
          if (cnt == CNT_LAST) begin
            if (NO_GAP) state <= ST_IDLE;
            else        state <= ST_GAP;
            so       <= 1'b0;
            so_valid <= 1'b0;
            so_first <= 1'b0;
            so_last  <= 1'b0;
          end else begin
            cnt      <= cnt + CW'(1);
            sreg     <= adv(sreg);
            so       <= head(sreg);
            so_first <= 1'b0;
            so_last  <= (cnt == CNT_PENULT);
          end
        end
        ST_GAP: begin
          if (gcnt == GAP_LAST) begin
            state <= ST_IDLE;
            gcnt  <= '0;
          end else begin
            gcnt  <= gcnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: four parameter variants driven together and checked
// every cycle against a bit-list model, plus literal frame expectations.
module tb_piso_shift_tx;
  localparam int NI = 4;
  localparam logic [NI-1:0][5:0] PW = {6'd8, 6'd5, 6'd5, 6'd5};
  localparam logic [NI-1:0]      PM = 4'b0101;
  localparam logic [NI-1:0][3:0] PG = {4'd3, 4'd2, 4'd0, 4'd0};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   pi_data = '0;
  logic [NI-1:0] pi_valid = '0;
  logic [NI-1:0] pi_ready, so, so_valid, so_first, so_last, busy;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    piso_shift_tx #(
      .WIDTH(int'(PW[g])), .MSB_FIRST(int'(PM[g])), .GAP(int'(PG[g]))
    ) u_dut (
      .clk(clk), .rst(rst), .pi_data(pi_data[PW[g]-1:0]), .pi_valid(pi_valid[g]),
      .pi_ready(pi_ready[g]), .so(so[g]), .so_valid(so_valid[g]),
      .so_first(so_first[g]), .so_last(so_last[g]), .busy(busy[g])
    );
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each frame is a list of bits in send order; midx is the bit on the
  // wire this cycle (-1 = none), gap_left the idle cycles still owed.
  logic [31:0] mbits [NI];
  int          midx [NI];
  int          gap_left [NI];

  function automatic bit m_ready(input int i);
    return (midx[i] < 0 && gap_left[i] == 0) ||
           (midx[i] == int'(PW[i]) - 1 && PG[i] == 4'd0);
  endfunction

  task automatic m_load(input int i, input logic [31:0] d);
    int w;
    w = int'(PW[i]);
    mbits[i] = '0;
    for (int j = 0; j < w; j++) mbits[i][j] = PM[i] ? d[w-1-j] : d[j];
    midx[i] = 0;
  endtask

  initial begin
    bit          acc;
    int          w;
    logic [5:0]  exp_o, act_o;
    for (int i = 0; i < NI; i++) begin
      midx[i] = -1;
      gap_left[i] = 0;
      mbits[i] = '0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
        w = int'(PW[i]);
        acc = pi_valid[i] && m_ready(i);
        if (rst) begin
          midx[i] = -1;
          gap_left[i] = 0;
        end else if (midx[i] >= 0) begin
          if (midx[i] == w - 1) begin
            if (acc) m_load(i, pi_data);
            else begin
              midx[i] = -1;
              gap_left[i] = int'(PG[i]);
            end
          end else midx[i]++;
        end else if (gap_left[i] > 0) gap_left[i]--;
        else if (acc) m_load(i, pi_data);
      end
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        exp_o = '0;
        exp_o[5] = m_ready(i);
        if (midx[i] >= 0) begin
          exp_o[4] = mbits[i][midx[i]];
          exp_o[3] = 1'b1;
          exp_o[2] = (midx[i] == 0);
          exp_o[1] = (midx[i] == int'(PW[i]) - 1);
        end
        exp_o[0] = (midx[i] >= 0) || (gap_left[i] > 0);
        act_o = {pi_ready[i], so[i], so_valid[i], so_first[i], so_last[i], busy[i]};
        chk($sformatf("model_outs[%0d] {rdy,so,vld,first,last,busy}", i),
            32'(act_o), 32'(exp_o));
      end
    end
  end

  // Capture of emitted bits for the literal frame checks.
  logic [31:0] col [NI];
  logic [31:0] colf [NI];
  logic [31:0] coll [NI];
  int          ncol [NI];
  int          cyc = 0;
  int          cfirst [$];

  initial forever begin
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (so_valid[i]) begin
        col[i]  = {col[i][30:0], so[i]};
        colf[i] = {colf[i][30:0], so_first[i]};
        coll[i] = {coll[i][30:0], so_last[i]};
        ncol[i]++;
      end
    end
    if (so_first[2]) cfirst.push_back(cyc);
  end

  task automatic clr();
    for (int i = 0; i < NI; i++) begin
      col[i] = '0;
      colf[i] = '0;
      coll[i] = '0;
      ncol[i] = 0;
    end
    cfirst.delete();
  endtask

  initial begin
    clr();
    // Reset held with pi_valid high: nothing may start.
    rst = 1'b1;
    pi_valid = '1;
    pi_data = 32'b10110;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 32'({so_valid, so_first, so_last, busy, so}), 32'd0);
    @(posedge clk); #2;
    clr();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(pi_ready), 32'hF);

    // 10110 then 01001, offered continuously.
    @(posedge clk); #2;
    pi_data = 32'b01001;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("ready_on_last_bit", 32'({pi_ready[0], so_last[0]}), 32'b11);
    @(posedge clk); #2;
    pi_valid[1:0] = 2'b00;
    repeat (3) @(posedge clk); #2;
    pi_valid[3:2] = 2'b00;
    repeat (20) @(posedge clk); #2;
    chk("b2b_count", 32'(ncol[0]), 32'd10);
    chk("b2b_bits", 32'(col[0][9:0]), 32'b1011001001);
    chk("b2b_first", 32'(colf[0][9:0]), 32'b1000010000);
    chk("b2b_last", 32'(coll[0][9:0]), 32'b0000100001);
    chk("lsb_count", 32'(ncol[1]), 32'd10);
    chk("lsb_bits", 32'(col[1][9:0]), 32'b0110110010);
    chk("gap_bits", 32'(col[2][9:0]), 32'b1011001001);
    chk("gap_frames", 32'(cfirst.size()), 32'd2);
    if (cfirst.size() == 2) chk("gap_spacing", 32'(cfirst[1] - cfirst[0]), 32'd8);
    chk("w8_count", 32'(ncol[3]), 32'd8);
    chk("w8_bits", 32'(col[3][7:0]), 32'b01101000);

    // Abort 11111 with reset during bit 2, then send 00001.
    clr();
    pi_valid[0] = 1'b1;
    pi_data = 32'b11111;
    @(posedge clk); #2;
    pi_valid[0] = 1'b0;
    repeat (2) @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_quiet", 32'({so_valid[0], so[0]}), 32'd0);
    chk("abort_count", 32'(ncol[0]), 32'd3);
    chk("abort_bits", 32'(col[0][2:0]), 32'b111);
    chk("abort_no_last", coll[0], 32'd0);
    @(posedge clk); #2;
    clr();
    pi_valid[0] = 1'b1;
    pi_data = 32'b00001;
    @(posedge clk); #2;
    pi_valid[0] = 1'b0;
    repeat (6) @(posedge clk); #2;
    chk("after_abort_count", 32'(ncol[0]), 32'd5);
    chk("after_abort_bits", 32'(col[0][4:0]), 32'b00001);
    chk("after_abort_last", 32'(coll[0][4:0]), 32'b00001);

    // Random traffic with occasional reset.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      rst = ($urandom_range(0, 63) == 0);
      pi_valid = NI'($urandom);
      pi_data = $urandom;
    end
    @(posedge clk); #2;
    rst = 1'b0;
    pi_valid = '0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
